fft_seq_ctl: RTL and testbench

FFT_SEQ_CTL -- requirements
Module: fft_seq_ctl

---
 rtl/fft_seq_ctl.sv | 161 ++++++++++++++++
 tb/tb_fft_seq_ctl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctl.sv
// fft_seq_ctl: radix-4 FFT pipeline sequencer (IDLE/FILL/RUN/FLUSH), sync active-low reset.
// in: clk rst_n in_valid in_sop flush_req; out: in_ready adv stage_en out_valid/sop/eop sop_err busy; FFT_SEQ_FRAME_CNT_EN adds frame_cnt.
module fft_seq_ctl #(
  parameter int LOG4_N    = 4,
  parameter int STAGE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              flush_req,
  output logic              in_ready,
  output logic              adv,
  output logic [LOG4_N-1:0] stage_en,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic              sop_err,
  output logic              busy
`ifdef FFT_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int S  = LOG4_N;
  localparam int IW = 2 * S;

  // Advance count at which stage k has seen its first valid data.
  function automatic int thr(input int k);
    int t;
    t = 0;
    for (int j = 0; j < k; j++)
      t += 3 * (4 ** (S - 1 - j)) + STAGE_LAT;
    return t;
  endfunction

  localparam int             TS   = thr(S);
  localparam int             FW   = $clog2(TS + 1);
  localparam logic [FW-1:0]  TS_F = FW'(TS);
  localparam logic [IW-1:0]  LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] fc_q, fc_d, fc_inc;
  logic [IW-1:0] ii_q, ii_d;
  logic [IW-1:0] oi_q, oi_d;
  logic [S-1:0]  stage_en_q, stage_en_d;
  logic          sop_err_q, sop_err_d;
  logic          acc;
  logic          in_run;

  always_comb begin
    in_ready = (state_q != FLUSH);
    acc      = in_valid & in_ready;
    in_run   = (state_q == FILL) | (state_q == RUN);

    unique case (1'b1)
      (state_q == IDLE):  adv = acc & in_sop;
      (state_q == FLUSH): adv = 1'b1;
      default:            adv = acc;
    endcase

    out_valid = adv & ((state_q == RUN) | (state_q == FLUSH));
    out_sop   = out_valid & (oi_q == '0);
    out_eop   = out_valid & (oi_q == LAST);

    // fc saturates at the fill latency so it cannot wrap in RUN.
    fc_inc = (adv && fc_q != TS_F) ? fc_q + 1'b1 : fc_q;

    state_d   = state_q;
    fc_d      = fc_inc;
    ii_d      = ii_q;
    oi_d      = out_valid ? oi_q + 1'b1 : oi_q;
    sop_err_d = sop_err_q | (in_run & acc & in_sop & (ii_q != '0));

    if (in_run && acc)
      ii_d = ii_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        // The starting sample is index 0, so the next one is 1.
        if (adv) begin
          state_d = FILL;
          fc_d    = '0;
          ii_d    = IW'(1);
        end
      end
      FILL: begin
        if (adv && fc_inc == TS_F)
          state_d = RUN;
      end
      RUN: begin
        if (acc && ii_q == LAST && flush_req) begin
          state_d = FLUSH;
          fc_d    = '0;
        end
      end
      FLUSH: begin
        // The cycle with fc at T_S still advances out the last sample.
        if (fc_q == TS_F) begin
          state_d = IDLE;
          fc_d    = '0;
          ii_d    = '0;
        end
      end
      default: ;
    endcase

    stage_en_d = '1;
    if (state_d == IDLE)
      stage_en_d = '0;
    else if (state_d == FILL)
      for (int k = 0; k < S; k++)
        stage_en_d[k] = int'(fc_d) >= thr(k);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fc_q       <= '0;
      ii_q       <= '0;
      oi_q       <= '0;
      stage_en_q <= '0;
      sop_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fc_q       <= fc_d;
      ii_q       <= ii_d;
      oi_q       <= oi_d;
      stage_en_q <= stage_en_d;
      sop_err_q  <= sop_err_d;
    end
  end

  assign stage_en = stage_en_q;
  assign sop_err  = sop_err_q;
  assign busy     = (state_q != IDLE);

`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_cnt_q + {15'd0, out_eop};

  always_ff @(posedge clk) begin
    if (!rst_n)
      frame_cnt_q <= '0;
    else
      frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_seq_ctl.sv
// tb_fft_seq_ctl: random + directed stimulus against a token-pipe model.
// The model tracks samples as tagged tokens through a T_S+1 deep queue.
module tb_fft_seq_ctl;
  localparam int S   = 4;
  localparam int LAT = 1;
  localparam int N   = 4 ** S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_sop = 1'b0;
  logic flush_req = 1'b0;
  logic in_ready, adv, out_valid, out_sop, out_eop, sop_err, busy;
  logic [S-1:0] stage_en;
`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  fft_seq_ctl #(.LOG4_N(S), .STAGE_LAT(LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_sop(in_sop),
    .flush_req(flush_req),
    .in_ready(in_ready),
    .adv(adv),
    .stage_en(stage_en),
    .out_valid(out_valid),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .sop_err(sop_err),
    .busy(busy)
`ifdef FFT_SEQ_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int th[S+1];
  int ts;

  int mode;
  int m_cnt;
  int m_inf;
  int m_eops;
  bit m_err;
  int pipe[$];

  int n_adv, n_cyc, n_acc, n_ov, n_eop;
  int f_se_a[S];
  int f_se_c[S];
  int f_sop_a, f_sop_c, f_rdy;
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    mode   = 0;
    m_cnt  = 0;
    m_inf  = 0;
    m_eops = 0;
    m_err  = 1'b0;
    pipe.delete();
    for (int i = 0; i <= ts; i++)
      pipe.push_back(-1);
  endtask

  task automatic clr_stats();
    n_adv = 0;
    n_cyc = 0;
    n_acc = 0;
    n_ov  = 0;
    n_eop = 0;
    f_sop_a = -1;
    f_sop_c = -1;
    f_rdy = -1;
    for (int k = 0; k < S; k++) begin
      f_se_a[k] = -1;
      f_se_c[k] = -1;
    end
  endtask

  task automatic step(input bit v, input bit s, input bit f,
                      input bit r = 1'b1);
    bit e_rdy, e_adv;
    int tok, em, idx;
    logic [S-1:0] e_se;
    @(negedge clk);
    rst_n = r;
    in_valid = v;
    in_sop = s;
    flush_req = f;
    #1;
    if (!r) begin
      m_reset();
      last_acc = 1'b0;
      @(posedge clk);
      return;
    end
    e_rdy = (mode != 2);
    e_adv = (mode == 2) ? 1'b1 : (mode == 1) ? v : (v & s);
    idx = (mode == 1) ? (m_cnt + 1) % N : 0;
    tok = (mode == 2) ? -1 : idx;
    em = -1;
    if (e_adv) begin
      em = pipe.pop_front();
      pipe.push_back(tok);
    end
    for (int k = 0; k < S; k++)
      e_se[k] = (mode == 2) || (mode == 1 && m_cnt >= th[k]);

    chk("in_ready", in_ready, e_rdy);
    chk("adv", adv, e_adv);
    chk("out_valid", out_valid, em >= 0);
    chk("out_sop", out_sop, em == 0);
    chk("out_eop", out_eop, em == N - 1);
    chk("stage_en", stage_en, e_se);
    chk("busy", busy, mode != 0);
    chk("sop_err", sop_err, m_err);
`ifdef FFT_SEQ_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, m_eops % 65536);
`endif

    if (f_rdy < 0 && in_ready === 1'b0)
      f_rdy = n_acc;
    for (int k = 0; k < S; k++)
      if (f_se_a[k] < 0 && stage_en[k] === 1'b1) begin
        f_se_a[k] = n_adv;
        f_se_c[k] = n_cyc;
      end
    if (f_sop_a < 0 && out_sop === 1'b1) begin
      f_sop_a = n_adv;
      f_sop_c = n_cyc;
    end
    if (adv === 1'b1) n_adv++;
    if (out_valid === 1'b1) n_ov++;
    if (out_eop === 1'b1) n_eop++;
    n_cyc++;
    last_acc = v & e_rdy & (mode != 0 || s);
    if (last_acc) n_acc++;

    if (e_adv) begin
      m_inf += int'(tok >= 0) - int'(em >= 0);
      if (em == N - 1) m_eops++;
      case (mode)
        0: begin
          mode = 1;
          m_cnt = 0;
        end
        1: begin
          m_cnt++;
          if (s && idx != 0) m_err = 1'b1;
          if (f && idx == N - 1 && m_cnt > ts) mode = 2;
        end
        default: begin
          if (m_inf == 0) begin
            mode = 0;
            m_cnt = 0;
          end
        end
      endcase
    end
    @(posedge clk);
  endtask

  task automatic send(input int nsamp, input int pv, input int fl_from,
                      input int bad, input int pul);
    int k;
    int guard;
    bit v;
    k = 0;
    guard = 0;
    while (k < nsamp && guard < 40 * nsamp + 100) begin
      v = ($urandom % 100) < pv;
      step(v, (k % N == 0) || (k == bad),
           (k >= fl_from) || (pul >= 0 && k >= pul && k < pul + 6));
      if (last_acc) k++;
      guard++;
    end
    if (k < nsamp) chk("send_timeout", k, nsamp);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (mode != 0 && g < 3000) begin
      step(1'b0, 1'b0, 1'b0);
      g++;
    end
    if (mode != 0) chk("drain_timeout", g, 0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    th[0] = 0;
    for (int k = 0; k < S; k++)
      th[k+1] = th[k] + 3 * (4 ** (S - 1 - k)) + LAT;
    ts = th[S];
    m_reset();
    clr_stats();

    // reset state, then junk samples without sop are dropped
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // three back-to-back frames, flush in the third
    clr_stats();
    send(3 * N, 100, 2 * N + 100, -1, -1);
    drain();
    for (int k = 1; k < S; k++)
      chk($sformatf("se%0d_rise", k), f_se_a[k], th[k] + 1);
    chk("first_sop", f_sop_a, ts + 1);
    chk("rdy_low_at", f_rdy, 3 * N);
    chk("n_out", n_ov, 3 * N);
    chk("n_eop", n_eop, 3);
`ifdef FFT_SEQ_FRAME_CNT_EN
    chk("frame_cnt3", frame_cnt, 3);
`endif

    // 10-cycle gap mid-FILL shifts everything by 10
    do_reset();
    clr_stats();
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 300; k++) begin
      if (k == 100) repeat (10) step(1'b0, 1'b0, 1'b0);
      step(1'b1, (k % N) == 0, 1'b0);
    end
    for (int k = 1; k < S; k++)
      chk($sformatf("gap_se%0d", k), f_se_c[k], th[k] + 1 + 10);
    chk("gap_first_sop", f_sop_c, ts + 1 + 10);

    // reset at fc=200
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 400 && m_cnt < 200; g++)
      step(1'b1, 1'b0, 1'b0);
    chk("fc200_reached", m_cnt, 200);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_stage_en", stage_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_adv", adv, 0);
    step(1'b0, 1'b0, 1'b0);

    // misaligned sop at ii=5
    clr_stats();
    send(2 * N, 100, N + 10, 5, -1);
    drain();
    #2;
    chk("sop_err_sticky", sop_err, 1);
    chk("bad_first_sop", f_sop_a, ts + 1);
    do_reset();

    // randomized frames, gaps, flush pulses and aborts
    for (int it = 0; it < 6; it++) begin
      int nf, pv, ff, bad, pul;
      bit abort;
      nf = $urandom_range(2, 3);
      pv = $urandom_range(55, 100);
      ff = (nf - 1) * N + $urandom_range(0, N - 1);
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nf * N - 1) : -1;
      pul = $urandom_range(10, N - 20);
      abort = ($urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, 1'b0);
      if (abort) begin
        send(N + $urandom_range(0, N), pv, nf * N, bad, pul);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
      end else begin
        send(nf * N, pv, ff, bad, pul);
        drain();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
